lpgbt_uplink_frame_capture: RTL and testbench

- Parametrised uplink frame monitor and capture buffer in the clk40 domain, directly downstream of the lpGBT-FPGA uplink core.
- Qualifies link lock with a debounced state machine and keeps saturating frame, FEC-error and lock-loss counters.
- On an armed trigger, captures DEPTH frames of DATA_WIDTH bits; software drains them word by word through a register-side read port.
- CDC to the AXI domain is done outside this block.

---
 rtl/lpgbt_uplink_frame_capture.sv | 254 +++++++++++++++++++++++++
 tb/tb_lpgbt_uplink_frame_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lpgbt_uplink_frame_capture.sv
// lpgbt_uplink_frame_capture
// Uplink frame monitor and capture buffer in the clk40 domain.
// - Link qualification FSM: UNLOCKED / ACQUIRE / LOCKED.
// - Saturating frame, FEC-error and lock-loss counters.
// - Capture FSM: IDLE / ARMED / CAPTURE / DONE.
// - DEPTH-frame buffer, drained word by word through a read port.
// Build option: define LPGBT_CAPTURE_PRETRIG_EN to keep the last PRETRIG
// locked frames seen while ARMED as pre-trigger history.
module lpgbt_uplink_frame_capture #(
  parameter int DATA_WIDTH  = 234,
  parameter int WORD_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int LOCK_CYCLES = 64,
  parameter int CNT_WIDTH   = 32,
  parameter int PRETRIG     = 4
) (
  input  logic                     clk40_i,
  input  logic                     rst_i,
  input  logic                     frame_valid_i,
  input  logic                     uplinkrdy_i,
  input  logic                     uplinkFEC_i,
  input  logic [DATA_WIDTH-1:0]    uplinkUserData_i,
  input  logic                     arm_i,
  input  logic                     trig_i,
  input  logic                     clear_cnt_i,
  input  logic                     rd_en_i,
  output logic [WORD_WIDTH-1:0]    rd_data_o,
  output logic                     rd_valid_o,
  output logic [1:0]               link_state_o,
  output logic [1:0]               cap_state_o,
  output logic                     truncated_o,
  output logic [$clog2(DEPTH):0]   fill_level_o,
  output logic [CNT_WIDTH-1:0]     frame_cnt_o,
  output logic [CNT_WIDTH-1:0]     fec_err_cnt_o,
  output logic [CNT_WIDTH-1:0]     lock_loss_cnt_o
);

  localparam int NWORDS = (DATA_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int PAD_W  = NWORDS * WORD_WIDTH;
  localparam int AW     = $clog2(DEPTH);
  localparam int FILL_W = AW + 1;
  localparam int WI_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int ACQ_W  = $clog2(LOCK_CYCLES + 1);
`ifdef LPGBT_CAPTURE_PRETRIG_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    LINK_UNLOCKED = 2'd0,
    LINK_ACQUIRE  = 2'd1,
    LINK_LOCKED   = 2'd2
  } link_state_t;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARMED   = 2'd1,
    CAP_CAPTURE = 2'd2,
    CAP_DONE    = 2'd3
  } cap_state_t;

  link_state_t             link_state_r, link_next_s;
  cap_state_t              cap_state_r, cap_next_s;
  logic [ACQ_W-1:0]        acq_cnt_r, acq_next_s;
  logic                    lock_lost_s, link_locked_s;
  logic                    wr_en_s, drop_oldest_s, set_trunc_s;
  logic                    rd_ok_s, last_word_s, pop_frame_s;
  logic [AW-1:0]           wr_ptr_r, rd_ptr_r;
  logic [FILL_W-1:0]       fill_r;
  logic [WI_W-1:0]         word_idx_r;
  logic [WORD_WIDTH-1:0]   rd_data_r, rd_word_s;
  logic                    rd_valid_r, truncated_r;
  logic [PAD_W-1:0]        pad_frame_s;
  logic [CNT_WIDTH-1:0]    frame_cnt_r, fec_cnt_r, loss_cnt_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    else    return v + CNT_WIDTH'(1);
  endfunction

  assign link_locked_s = (link_state_r == LINK_LOCKED);

  // Link qualification: count ready frames in ACQUIRE, flag LOCKED->UNLOCKED drops
  always_comb begin
    link_next_s = link_state_r;
    acq_next_s  = acq_cnt_r;
    lock_lost_s = 1'b0;
    case (link_state_r)
      LINK_UNLOCKED: begin
        acq_next_s = {ACQ_W{1'b0}};
        if (uplinkrdy_i) link_next_s = LINK_ACQUIRE;
        else             link_next_s = LINK_UNLOCKED;
      end
      LINK_ACQUIRE: begin
        if (!uplinkrdy_i) begin
          link_next_s = LINK_UNLOCKED;
          acq_next_s  = {ACQ_W{1'b0}};
        end else if (frame_valid_i) begin
          if (acq_cnt_r == ACQ_W'(LOCK_CYCLES - 1)) begin
            link_next_s = LINK_LOCKED;
            acq_next_s  = {ACQ_W{1'b0}};
          end else begin
            acq_next_s  = acq_cnt_r + ACQ_W'(1);
          end
        end else begin
          acq_next_s = acq_cnt_r;
        end
      end
      LINK_LOCKED: begin
        if (!uplinkrdy_i) begin
          link_next_s = LINK_UNLOCKED;
          lock_lost_s = 1'b1;
        end else begin
          link_next_s = LINK_LOCKED;
        end
      end
      default: begin
        link_next_s = LINK_UNLOCKED;
        acq_next_s  = {ACQ_W{1'b0}};
      end
    endcase
  end

  // Capture control: arm has priority; decides buffer writes and state moves
  always_comb begin
    cap_next_s    = cap_state_r;
    wr_en_s       = 1'b0;
    drop_oldest_s = 1'b0;
    set_trunc_s   = 1'b0;
    if (arm_i) begin
      cap_next_s = CAP_ARMED;
    end else begin
      case (cap_state_r)
        CAP_IDLE: cap_next_s = CAP_IDLE;
        CAP_ARMED: begin
          if (trig_i && link_locked_s) begin
            wr_en_s = frame_valid_i;
            if (frame_valid_i && (fill_r == FILL_W'(DEPTH - 1))) cap_next_s = CAP_DONE;
            else                                                 cap_next_s = CAP_CAPTURE;
          end else begin
            // Pre-trigger history: ring of the last PRETRIG locked frames
            wr_en_s       = PRE_EN && frame_valid_i && link_locked_s;
            drop_oldest_s = wr_en_s && (fill_r == FILL_W'(PRETRIG));
            cap_next_s    = CAP_ARMED;
          end
        end
        CAP_CAPTURE: begin
          if (!link_locked_s) begin
            cap_next_s  = CAP_DONE;
            set_trunc_s = 1'b1;
          end else if (frame_valid_i) begin
            wr_en_s = 1'b1;
            if (fill_r == FILL_W'(DEPTH - 1)) cap_next_s = CAP_DONE;
            else                              cap_next_s = CAP_CAPTURE;
          end else begin
            cap_next_s = CAP_CAPTURE;
          end
        end
        CAP_DONE: cap_next_s = CAP_DONE;
        default:  cap_next_s = CAP_IDLE;
      endcase
    end
  end

  // Readout word select: oldest frame, zero-padded to a whole number of words
  always_comb begin
    pad_frame_s = {PAD_W{1'b0}};
    pad_frame_s[DATA_WIDTH-1:0] = mem_r[rd_ptr_r];
    rd_word_s   = pad_frame_s[int'(word_idx_r) * WORD_WIDTH +: WORD_WIDTH];
    rd_ok_s     = rd_en_i && !arm_i && (cap_state_r == CAP_DONE) &&
                  (fill_r != {FILL_W{1'b0}});
    last_word_s = (word_idx_r == WI_W'(NWORDS - 1));
    pop_frame_s = rd_ok_s && last_word_s;
  end

  // State registers for both FSMs and the acquire counter
  always_ff @(posedge clk40_i or posedge rst_i) begin
    if (rst_i) begin
      link_state_r <= LINK_UNLOCKED;
      cap_state_r  <= CAP_IDLE;
      acq_cnt_r    <= {ACQ_W{1'b0}};
    end else begin
      link_state_r <= link_next_s;
      cap_state_r  <= cap_next_s;
      acq_cnt_r    <= acq_next_s;
    end
  end

  // Saturating status counters; clear beats a same-cycle increment
  always_ff @(posedge clk40_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_r <= {CNT_WIDTH{1'b0}};
      fec_cnt_r   <= {CNT_WIDTH{1'b0}};
      loss_cnt_r  <= {CNT_WIDTH{1'b0}};
    end else if (clear_cnt_i) begin
      frame_cnt_r <= {CNT_WIDTH{1'b0}};
      fec_cnt_r   <= {CNT_WIDTH{1'b0}};
      loss_cnt_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      if (link_locked_s && frame_valid_i)               frame_cnt_r <= sat_inc(frame_cnt_r);
      if (link_locked_s && frame_valid_i && uplinkFEC_i) fec_cnt_r  <= sat_inc(fec_cnt_r);
      if (lock_lost_s)                                   loss_cnt_r <= sat_inc(loss_cnt_r);
    end
  end

  // Frame storage; contents need no reset
  always_ff @(posedge clk40_i) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= uplinkUserData_i;
  end

  // Buffer pointers, fill level, readout registers and truncation flag
  always_ff @(posedge clk40_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      fill_r      <= {FILL_W{1'b0}};
      word_idx_r  <= {WI_W{1'b0}};
      rd_data_r   <= {WORD_WIDTH{1'b0}};
      rd_valid_r  <= 1'b0;
      truncated_r <= 1'b0;
    end else if (arm_i) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      fill_r      <= {FILL_W{1'b0}};
      word_idx_r  <= {WI_W{1'b0}};
      rd_valid_r  <= 1'b0;
      truncated_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_ok_s;
      if (rd_ok_s) begin
        rd_data_r  <= rd_word_s;
        word_idx_r <= last_word_s ? {WI_W{1'b0}} : word_idx_r + WI_W'(1);
      end
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (drop_oldest_s || pop_frame_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      if (wr_en_s && !drop_oldest_s) fill_r <= fill_r + FILL_W'(1);
      else if (pop_frame_s)          fill_r <= fill_r - FILL_W'(1);
      if (set_trunc_s) truncated_r <= 1'b1;
    end
  end

  assign rd_data_o       = rd_data_r;
  assign rd_valid_o      = rd_valid_r;
  assign link_state_o    = link_state_r;
  assign cap_state_o     = cap_state_r;
  assign truncated_o     = truncated_r;
  assign fill_level_o    = fill_r;
  assign frame_cnt_o     = frame_cnt_r;
  assign fec_err_cnt_o   = fec_cnt_r;
  assign lock_loss_cnt_o = loss_cnt_r;

endmodule

// File: tb/tb_lpgbt_uplink_frame_capture.sv
// Self-checking bench for lpgbt_uplink_frame_capture (default parameters).
// Honours LPGBT_CAPTURE_PRETRIG_EN for the pre-trigger readout expectations.
module tb_lpgbt_uplink_frame_capture;

  localparam int DW = 234;

  logic          clk = 1'b0;
  logic          rst, fv, rdy, fec, arm, trig, clr, rd_en;
  logic [DW-1:0] data;
  logic [31:0]   rd_data;
  logic          rd_valid, truncated;
  logic [1:0]    link_state, cap_state;
  logic [4:0]    fill;
  logic [31:0]   frm_cnt, fec_cnt, loss_cnt;

  int checks = 0;
  int errors = 0;

  lpgbt_uplink_frame_capture dut (
    .clk40_i(clk), .rst_i(rst), .frame_valid_i(fv), .uplinkrdy_i(rdy),
    .uplinkFEC_i(fec), .uplinkUserData_i(data), .arm_i(arm), .trig_i(trig),
    .clear_cnt_i(clr), .rd_en_i(rd_en), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .link_state_o(link_state), .cap_state_o(cap_state), .truncated_o(truncated),
    .fill_level_o(fill), .frame_cnt_o(frm_cnt), .fec_err_cnt_o(fec_cnt),
    .lock_loss_cnt_o(loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         reps;
    logic       rdy, fv, fec, arm, trig, clr;
    logic [1:0] exp_link, exp_cap;
    int         exp_frm, exp_fec, exp_loss;
  } vec_t;

  vec_t tab[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Payload: low 32 bits carry the frame id, all remaining bits are ones
  function automatic logic [DW-1:0] payload(input int id);
    logic [DW-1:0] p;
    p = '1;
    p[31:0] = 32'(id);
    return p;
  endfunction

  // Word w of payload(id): 234 bits -> 8 words, top word keeps 10 bits
  function automatic logic [31:0] exp_word(input int id, input int w);
    if (w == 0)      return 32'(id);
    else if (w == 7) return 32'h0000_03ff;
    else             return 32'hffff_ffff;
  endfunction

  task automatic read_frames(input int first_id, input int nframes, input int start_fill);
    for (int k = 0; k < nframes; k++) begin
      for (int w = 0; w < 8; w++) begin
        rd_en = 1'b1;
        step();
        chk("rd_valid", 64'(rd_valid), 64'd1);
        chk("rd_data", 64'(rd_data), 64'(exp_word(first_id + k, w)));
      end
      chk("fill_after_frame", 64'(fill), 64'(start_fill - k - 1));
    end
    rd_en = 1'b0;
  endtask

  task automatic lock_link();
    rdy = 1'b1; fv = 1'b1; fec = 1'b0; data = '0;
    repeat (65) step();
    chk("relock", 64'(link_state), 64'd2);
    fv = 1'b0;
  endtask

  task automatic do_arm();
    fv = 1'b0; arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic send_frames(input int first_id, input int n, input bit trig_first);
    for (int i = 0; i < n; i++) begin
      fv = 1'b1; data = payload(first_id + i);
      trig = trig_first && (i == 0);
      step();
    end
    fv = 1'b0; trig = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    int exp_first, exp_last, exp_pre_fill;

    //           reps rdy fv fec arm trig clr link cap frm fec loss
    tab[0]  = '{1,  1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd1,2'd0,   0,0,0};
    tab[1]  = '{40, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd1,2'd0,   0,0,0};
    tab[2]  = '{1,  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,   0,0,0};
    tab[3]  = '{1,  1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd1,2'd0,   0,0,0};
    tab[4]  = '{63, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd1,2'd0,   0,0,0};
    tab[5]  = '{1,  1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd0,   0,0,0};
    tab[6]  = '{50, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd0,  50,0,0};
    tab[7]  = '{1,  1'b1,1'b1,1'b1,1'b0,1'b0,1'b1, 2'd2,2'd0,   0,0,0};
    tab[8]  = '{97, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd0,  97,0,0};
    tab[9]  = '{3,  1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'd2,2'd0, 100,3,0};
    tab[10] = '{1,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'd2,2'd0, 100,3,0};
    tab[11] = '{1,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0, 100,3,1};
    tab[12] = '{1,  1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'd0,2'd0, 100,3,1};
    tab[13] = '{1,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd0,2'd0,   0,0,0};
    tab[14] = '{1,  1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'd0,2'd1,   0,0,0};
    tab[15] = '{1,  1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 2'd0,2'd1,   0,0,0};

    rst = 1'b1; fv = 1'b0; rdy = 1'b0; fec = 1'b0; arm = 1'b0;
    trig = 1'b0; clr = 1'b0; rd_en = 1'b0; data = '0;
    repeat (3) step();
    chk("rst_link", 64'(link_state), 64'd0);
    chk("rst_cap", 64'(cap_state), 64'd0);
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_trunc", 64'(truncated), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_counters", 64'(frm_cnt | fec_cnt | loss_cnt), 64'd0);
    rst = 1'b0;
    step();

    // Link FSM and counters, table-driven
    for (int i = 0; i < 16; i++) begin
      rdy = tab[i].rdy; fv = tab[i].fv; fec = tab[i].fec;
      arm = tab[i].arm; trig = tab[i].trig; clr = tab[i].clr;
      repeat (tab[i].reps) step();
      chk($sformatf("v%0d_link", i), 64'(link_state), 64'(tab[i].exp_link));
      chk($sformatf("v%0d_cap", i),  64'(cap_state),  64'(tab[i].exp_cap));
      chk($sformatf("v%0d_frm", i),  64'(frm_cnt),    64'(tab[i].exp_frm));
      chk($sformatf("v%0d_fec", i),  64'(fec_cnt),    64'(tab[i].exp_fec));
      chk($sformatf("v%0d_loss", i), 64'(loss_cnt),   64'(tab[i].exp_loss));
    end
    arm = 1'b0; trig = 1'b0; clr = 1'b0; fv = 1'b0; fec = 1'b0;

    // Full capture of 16 frames, then full readout
    lock_link();
    do_arm();
    chk("s1_armed", 64'(cap_state), 64'd1);
    chk("s1_fill0", 64'(fill), 64'd0);
    send_frames(0, 1, 1'b1);
    chk("s1_capture", 64'(cap_state), 64'd2);
    send_frames(1, 15, 1'b0);
    chk("s1_done", 64'(cap_state), 64'd3);
    chk("s1_fill16", 64'(fill), 64'd16);
    trig = 1'b1; step(); trig = 1'b0;
    chk("s1_trig_in_done", 64'(cap_state), 64'd3);
    chk("s1_no_early_valid", 64'(rd_valid), 64'd0);
    read_frames(0, 16, 16);
    step();
    chk("s1_valid_pulse", 64'(rd_valid), 64'd0);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("s1_empty_read_valid", 64'(rd_valid), 64'd0);
    chk("s1_empty_read_hold", 64'(rd_data), 64'h3ff);

    // Truncated capture: link drops after 5 frames
    do_arm();
    chk("s2_armed", 64'(cap_state), 64'd1);
    send_frames(0, 1, 1'b1);
    send_frames(1, 4, 1'b0);
    rdy = 1'b0; fv = 1'b0;
    step(); step();
    chk("s2_done", 64'(cap_state), 64'd3);
    chk("s2_trunc", 64'(truncated), 64'd1);
    chk("s2_fill5", 64'(fill), 64'd5);
    chk("s2_loss", 64'(loss_cnt), 64'd1);
    read_frames(0, 5, 5);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("s2_read41_valid", 64'(rd_valid), 64'd0);
    chk("s2_read41_hold", 64'(rd_data), 64'h3ff);

    // Re-arm during CAPTURE
    lock_link();
    do_arm();
    chk("s3_arm_clears_trunc", 64'(truncated), 64'd0);
    send_frames(0, 1, 1'b1);
    send_frames(1, 2, 1'b0);
    chk("s3_capture", 64'(cap_state), 64'd2);
    chk("s3_fill3", 64'(fill), 64'd3);
    do_arm();
    chk("s3_rearm_state", 64'(cap_state), 64'd1);
    chk("s3_rearm_fill", 64'(fill), 64'd0);
    chk("s3_rearm_trunc", 64'(truncated), 64'd0);

    // Ten armed frames, then trigger and fill to DEPTH
`ifdef LPGBT_CAPTURE_PRETRIG_EN
    exp_pre_fill = 4; exp_first = 6;  exp_last = 21;
`else
    exp_pre_fill = 0; exp_first = 10; exp_last = 25;
`endif
    do_arm();
    send_frames(0, 10, 1'b0);
    chk("s4_armed", 64'(cap_state), 64'd1);
    chk("s4_pre_fill", 64'(fill), 64'(exp_pre_fill));
    id = 10;
    trig = 1'b1;
    while (cap_state != 2'd3 && id < 48) begin
      fv = 1'b1; data = payload(id);
      step();
      trig = 1'b0;
      id++;
    end
    fv = 1'b0;
    chk("s4_done", 64'(cap_state), 64'd3);
    chk("s4_last_id", 64'(id - 1), 64'(exp_last));
    chk("s4_fill16", 64'(fill), 64'd16);
    read_frames(exp_first, 16, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
